if_fetch_ctrl: RTL and testbench

- Instruction-fetch control stage that consumes the flow controller's IF-side jump and stall outputs.
- Owns the PC register and drives the Icache request and address.
- Tracks Icache hit and miss responses, buffers jump redirects that arrive while fetch cannot act on them, and presents the fetched instruction, its PC and a valid flag to the if_id register.

---
 rtl/if_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Purpose: IF stage control; owns the PC, issues Icache fetches, applies or buffers flow-control redirects.
// Latency: outputs are combinational from state and inputs; PC/state/pending-jump/buffered word update on each clk edge.
// Backpressure: fc_stall_if_i holds the PC and re-presents (or buffers) the current word; redirects are still captured while stalled.
//
// Ports:
//   clk, rst_n                          core clock, async active-low reset
//   fc_jump_flag_if_i/fc_jump_pc_if_i   one-cycle redirect pulse and its target
//   fc_stall_if_i                       IF stall from flow control
//   Icache_hit_i/Icache_inst_i          same-cycle hit and instruction word
//   bc_Icache_ready_i                   miss refill complete (Icache_inst_i valid)
//   if_req_Icache_o/if_pc_Icache_o      fetch request and address (= PC register)
//   if_inst_o/if_inst_pc_o/if_inst_valid_o  instruction, its PC and valid flag to if_id
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fc_jump_flag_if_i,
    input  logic [31:0] fc_jump_pc_if_i,
    input  logic        fc_stall_if_i,
    input  logic        Icache_hit_i,
    input  logic [31:0] Icache_inst_i,
    input  logic        bc_Icache_ready_i,
    output logic        if_req_Icache_o,
    output logic [31:0] if_pc_Icache_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_inst_pc_o,
    output logic        if_inst_valid_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;

    logic [31:0] pulse_tgt;
    logic [31:0] jump_tgt;
    logic        jump_any;
    logic [31:0] pc_inc;
    logic        apply_jump;
    logic        valid;
    logic [31:0] inst;

    always_comb begin
        // Targets are word aligned; a live pulse beats any older pending redirect.
        pulse_tgt  = fc_jump_pc_if_i & 32'hFFFF_FFFC;
        jump_tgt   = fc_jump_flag_if_i ? pulse_tgt : pend_pc_q;
        jump_any   = fc_jump_flag_if_i | pend_q;
        pc_inc     = pc_q + 32'd4;

        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        buf_inst_d = buf_inst_q;
        apply_jump = 1'b0;
        valid      = 1'b0;
        inst       = 32'h0;
        if_req_Icache_o = 1'b0;

        case (state_q)
            BOOT: begin
                // Any late refill pulse is ignored here.
                state_d = RUN;
            end
            RUN: begin
                if_req_Icache_o = 1'b1;
                if (Icache_hit_i) begin
                    if (fc_stall_if_i) begin
                        valid = 1'b1;
                        inst  = Icache_inst_i;
                    end else if (jump_any) begin
                        apply_jump = 1'b1;
                    end else begin
                        valid = 1'b1;
                        inst  = Icache_inst_i;
                        pc_d  = pc_inc;
                    end
                end else begin
                    state_d = MISS;
                end
            end
            MISS: begin
                if (bc_Icache_ready_i) begin
                    if (jump_any) begin
                        // Refilled word is on the wrong path; drop it.
                        apply_jump = 1'b1;
                    end else begin
                        valid = 1'b1;
                        inst  = Icache_inst_i;
                        if (fc_stall_if_i) begin
                            buf_inst_d = Icache_inst_i;
                            state_d    = HOLD;
                        end else begin
                            pc_d    = pc_inc;
                            state_d = RUN;
                        end
                    end
                end
            end
            HOLD: begin
                if (jump_any) begin
                    if (!fc_stall_if_i) begin
                        apply_jump = 1'b1;
                    end
                end else begin
                    valid = 1'b1;
                    inst  = buf_inst_q;
                    if (!fc_stall_if_i) begin
                        pc_d    = pc_inc;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Redirect applied this cycle clears the pending slot; otherwise a
        // live pulse is remembered (newest wins) until it can be applied.
        if (apply_jump) begin
            pc_d    = jump_tgt;
            pend_d  = 1'b0;
            state_d = RUN;
        end else if (fc_jump_flag_if_i) begin
            pend_d    = 1'b1;
            pend_pc_d = pulse_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_pc_q  <= 32'h0;
            buf_inst_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign if_pc_Icache_o  = pc_q;
    assign if_inst_valid_o = valid;
    assign if_inst_o       = inst;
    assign if_inst_pc_o    = valid ? pc_q : 32'h0;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jf = 1'b0;
    logic [31:0] jpc = 32'h0;
    logic        stall = 1'b0;
    logic        hit = 1'b0;
    logic [31:0] inst_in = 32'h0;
    logic        rdy = 1'b0;
    logic        req;
    logic [31:0] apc;
    logic [31:0] inst_out;
    logic [31:0] ipc;
    logic        vld;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fc_jump_flag_if_i (jf),
        .fc_jump_pc_if_i   (jpc),
        .fc_stall_if_i     (stall),
        .Icache_hit_i      (hit),
        .Icache_inst_i     (inst_in),
        .bc_Icache_ready_i (rdy),
        .if_req_Icache_o   (req),
        .if_pc_Icache_o    (apc),
        .if_inst_o         (inst_out),
        .if_inst_pc_o      (ipc),
        .if_inst_valid_o   (vld)
    );

    typedef struct packed {
        logic        jf;
        logic [31:0] jpc;
        logic        st;
        logic        hit;
        logic        rdy;
        logic [31:0] inst;
        logic        ereq;
        logic [31:0] eapc;
        logic        evld;
        logic [31:0] einst;
        logic [31:0] eipc;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic f, input logic [31:0] p, input logic s, input logic h,
                     input logic r, input logic [31:0] i, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        vec_t x;
        x = '{jf:f, jpc:p, st:s, hit:h, rdy:r, inst:i, ereq:er, eapc:ea, evld:ev, einst:ei, eipc:ep};
        tbl.push_back(x);
    endtask

    task automatic check(input string name, input logic er, input logic [31:0] ea,
                         input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        total++;
        if ({req, apc, vld, inst_out, ipc} !== {er, ea, ev, ei, ep}) begin
            bad++;
            $display("FAIL %s: got req=%b pc=%h vld=%b inst=%h ipc=%h, want req=%b pc=%h vld=%b inst=%h ipc=%h",
                     name, req, apc, vld, inst_out, ipc, er, ea, ev, ei, ep);
        end
    endtask

    // Reference model: tracks where fetch is (not started / running / waiting
    // for refill / holding a word), the PC, and a one-deep list of pending targets.
    bit          m_started, m_waiting, m_holding;
    logic [31:0] m_pc, m_held;
    logic [31:0] m_pend[$];

    function automatic logic [31:0] m_target();
        if (jf) return jpc & 32'hFFFF_FFFC;
        return m_pend[0];
    endfunction

    task automatic model_reset();
        m_started = 0; m_waiting = 0; m_holding = 0;
        m_pc = 32'h0; m_held = 32'h0;
        m_pend.delete();
    endtask

    task automatic model_check(input string name);
        bit jump;
        logic er, ev;
        logic [31:0] ei;
        jump = jf || (m_pend.size() != 0);
        er = 0; ev = 0; ei = 0;
        if (!m_started) begin
        end else if (m_waiting) begin
            ev = rdy && !jump;
            ei = Icache_word();
        end else if (m_holding) begin
            ev = !jump;
            ei = m_held;
        end else begin
            er = 1;
            ev = hit && (stall || !jump);
            ei = inst_in;
        end
        if (!ev) ei = 0;
        check(name, er, m_pc, ev, ei, ev ? m_pc : 32'h0);
    endtask

    function automatic logic [31:0] Icache_word();
        return inst_in;
    endfunction

    task automatic model_step();
        bit jump, apply;
        logic [31:0] tgt;
        jump = jf || (m_pend.size() != 0);
        tgt = jump ? m_target() : 32'h0;
        apply = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (m_waiting) begin
            if (rdy) begin
                if (jump) apply = 1;
                else if (stall) begin m_held = inst_in; m_waiting = 0; m_holding = 1; end
                else begin m_pc = m_pc + 32'd4; m_waiting = 0; end
            end
        end else if (m_holding) begin
            if (jump) apply = !stall;
            else if (!stall) begin m_pc = m_pc + 32'd4; m_holding = 0; end
        end else begin
            if (!hit) m_waiting = 1;
            else if (!stall) begin
                if (jump) apply = 1;
                else m_pc = m_pc + 32'd4;
            end
        end
        if (apply) begin
            m_pc = tgt; m_pend.delete(); m_waiting = 0; m_holding = 0;
        end else if (jf) begin
            m_pend.delete();
            m_pend.push_back(jpc & 32'hFFFF_FFFC);
        end
    endtask

    task automatic idle_inputs();
        jf = 0; jpc = 0; stall = 0; hit = 0; rdy = 0; inst_in = 0;
    endtask

    initial begin
        // jf, jpc, stall, hit, rdy, inst | req, addr, vld, inst, ipc
        v(0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);   // BOOT
        v(0, 32'h0,   0, 1, 0, 32'h0,   1, 32'h0,   1, 32'h0,   32'h0);
        v(0, 32'h0,   0, 1, 0, 32'h4,   1, 32'h4,   1, 32'h4,   32'h4);
        v(0, 32'h0,   1, 1, 0, 32'h8,   1, 32'h8,   1, 32'h8,   32'h8);   // stall x2
        v(0, 32'h0,   1, 1, 0, 32'h8,   1, 32'h8,   1, 32'h8,   32'h8);
        v(0, 32'h0,   0, 1, 0, 32'h8,   1, 32'h8,   1, 32'h8,   32'h8);
        v(1, 32'h103, 0, 1, 0, 32'hC,   1, 32'hC,   0, 32'h0,   32'h0);   // jump, aligned
        v(0, 32'h0,   0, 1, 0, 32'h100, 1, 32'h100, 1, 32'h100, 32'h100);
        v(1, 32'h20,  0, 1, 0, 32'h104, 1, 32'h104, 0, 32'h0,   32'h0);
        v(0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h20,  0, 32'h0,   32'h0);   // miss
        v(0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h20,  0, 32'h0,   32'h0);
        v(1, 32'h80,  0, 0, 0, 32'h0,   0, 32'h20,  0, 32'h0,   32'h0);   // jump in MISS
        v(0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h20,  0, 32'h0,   32'h0);
        v(0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h20,  0, 32'h0,   32'h0);
        v(0, 32'h0,   0, 0, 1, 32'h20,  0, 32'h20,  0, 32'h0,   32'h0);   // ready, discarded
        v(0, 32'h0,   0, 1, 0, 32'h80,  1, 32'h80,  1, 32'h80,  32'h80);
        v(1, 32'h40,  0, 1, 0, 32'h84,  1, 32'h84,  0, 32'h0,   32'h0);
        v(0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h40,  0, 32'h0,   32'h0);
        v(0, 32'h0,   1, 0, 1, 32'hDEADBEEF, 0, 32'h40, 1, 32'hDEADBEEF, 32'h40);
        v(0, 32'h0,   1, 0, 0, 32'h12345678, 0, 32'h40, 1, 32'hDEADBEEF, 32'h40);
        v(0, 32'h0,   1, 0, 0, 32'h12345678, 0, 32'h40, 1, 32'hDEADBEEF, 32'h40);
        v(0, 32'h0,   0, 0, 0, 32'h12345678, 0, 32'h40, 1, 32'hDEADBEEF, 32'h40);
        v(0, 32'h0,   0, 1, 0, 32'h44,  1, 32'h44,  1, 32'h44,  32'h44);
        v(1, 32'hFFFFFFFF, 0, 1, 0, 32'h48, 1, 32'h48, 0, 32'h0, 32'h0);
        v(0, 32'h0,   0, 1, 0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'hFFFFFFFC);
        v(0, 32'h0,   0, 1, 0, 32'h0,   1, 32'h0,   1, 32'h0,   32'h0);   // wrapped
        v(0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0,   32'h0);
        v(0, 32'h0,   1, 0, 1, 32'hAA,  0, 32'h4,   1, 32'hAA,  32'h4);
        v(1, 32'h200, 1, 0, 0, 32'h0,   0, 32'h4,   0, 32'h0,   32'h0);   // jump in HOLD
        v(0, 32'h0,   1, 0, 0, 32'h0,   0, 32'h4,   0, 32'h0,   32'h0);
        v(0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h4,   0, 32'h0,   32'h0);
        v(0, 32'h0,   0, 1, 0, 32'h200, 1, 32'h200, 1, 32'h200, 32'h200);
        v(1, 32'h300, 1, 1, 0, 32'h204, 1, 32'h204, 1, 32'h204, 32'h204); // captured under stall
        v(0, 32'h0,   0, 1, 0, 32'h204, 1, 32'h204, 0, 32'h0,   32'h0);
        v(0, 32'h0,   0, 1, 0, 32'h300, 1, 32'h300, 1, 32'h300, 32'h300);
        v(0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h304, 0, 32'h0,   32'h0);
        v(1, 32'h400, 0, 0, 0, 32'h0,   0, 32'h304, 0, 32'h0,   32'h0);
        v(1, 32'h500, 0, 0, 0, 32'h0,   0, 32'h304, 0, 32'h0,   32'h0);   // overwrites
        v(0, 32'h0,   0, 0, 1, 32'h304, 0, 32'h304, 0, 32'h0,   32'h0);
        v(0, 32'h0,   0, 1, 0, 32'h500, 1, 32'h500, 1, 32'h500, 32'h500);

        // Reset state
        idle_inputs();
        rst_n = 0;
        #12;
        check("reset_state", 0, 32'h0, 0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[k]) begin
            jf = tbl[k].jf; jpc = tbl[k].jpc; stall = tbl[k].st;
            hit = tbl[k].hit; rdy = tbl[k].rdy; inst_in = tbl[k].inst;
            #1;
            check($sformatf("vec%0d", k), tbl[k].ereq, tbl[k].eapc, tbl[k].evld, tbl[k].einst, tbl[k].eipc);
            @(negedge clk);
        end

        // Async reset in the middle of a miss; late refill lands in BOOT.
        idle_inputs();
        #1;
        check("pre_miss", 1, 32'h504, 0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        check("in_miss", 0, 32'h504, 0, 32'h0, 32'h0);
        #2;
        rst_n = 0;
        #1;
        check("async_reset", 0, 32'h0, 0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1;
        rdy = 1; inst_in = 32'h55;
        #1;
        check("late_ready_boot", 0, 32'h0, 0, 32'h0, 32'h0);
        @(negedge clk);
        rdy = 0; inst_in = 0;
        #1;
        check("run_after_reset", 1, 32'h0, 0, 32'h0, 32'h0);

        // Randomized run against the reference model.
        @(negedge clk);
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int n = 0; n < 3000; n++) begin
            jf      = ($urandom_range(0, 7) == 0);
            jpc     = $urandom;
            stall   = ($urandom_range(0, 3) == 0);
            hit     = ($urandom_range(0, 3) != 0);
            rdy     = ($urandom_range(0, 3) == 0);
            inst_in = $urandom;
            #1;
            model_check($sformatf("rand%0d", n));
            model_step();
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
